// File: rtl/sargantana_hpdc_pkg.sv
// Shared I$/HPDC address definitions: physical address and cache-line geometry.
package sargantana_hpdc_pkg;

    localparam int unsigned PADDR_W     = 40;
    localparam int unsigned LINE_OFF_W  = 6;
    localparam int unsigned LINE_ADDR_W = PADDR_W - LINE_OFF_W;

    typedef logic [LINE_ADDR_W-1:0] line_addr_t;

endpackage

// File: rtl/icache_miss_fifo.sv
// Circular line-address FIFO with per-entry valid bits; invalidation clears
// matching non-head entries so the presented head never changes under the adapter.
module icache_miss_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned LineW = 34
) (
    input  logic             clk_i,
    input  logic             reset_l,
    input  logic             i_push,
    input  logic [LineW-1:0] i_push_line,
    input  logic             i_pop,
    input  logic             i_inval,
    input  logic [LineW-1:0] i_inval_line,
    output logic [LineW-1:0] o_head_line,
    output logic             o_head_vld,
    output logic [LineW-1:0] o_tail_line,
    output logic             o_tail_vld,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [LineW-1:0] r_mem [Depth];
    logic [Depth-1:0] r_vld;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_cnt;
    logic [PtrW-1:0]  w_tail_ptr;

    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_line;
        end
    end

    // Push is applied after the invalidation sweep so a same-cycle enqueue stays valid.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_inval) begin
                for (int i = 0; i < Depth; i++) begin
                    if ((PtrW'(i) != r_rd_ptr) && (r_mem[i] == i_inval_line)) begin
                        r_vld[i] <= 1'b0;
                    end
                end
            end
            if (i_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + PtrW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_cnt <= r_cnt + CntW'(i_push) - CntW'(i_pop);
        end
    end

    assign w_tail_ptr  = r_wr_ptr - PtrW'(1);
    assign o_head_line = r_mem[r_rd_ptr];
    assign o_head_vld  = r_vld[r_rd_ptr];
    assign o_tail_line = r_mem[w_tail_ptr];
    assign o_tail_vld  = r_vld[w_tail_ptr];
    assign o_empty     = (r_cnt == '0);
    assign o_full      = (r_cnt == CntW'(Depth));

endmodule

// File: rtl/icache_miss_req_queue.sv
// I$ miss request queue: dedups, buffers and issues core misses to the L1.5
// adapter while bounding the number of unanswered misses.
module icache_miss_req_queue
    import sargantana_hpdc_pkg::*;
#(
    parameter int unsigned Depth          = 4,
    parameter int unsigned AddrWidth      = PADDR_W,
    parameter int unsigned LineOffW       = LINE_OFF_W,
    parameter int unsigned MaxOutstanding = 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_l,
    input  logic                                 core_miss_valid_i,
    input  logic [AddrWidth-1:0]                 core_miss_paddr_i,
    output logic                                 l15_miss_valid_o,
    input  logic                                 l15_miss_ready_i,
    output logic [AddrWidth-1:0]                 l15_miss_paddr_o,
    input  logic                                 l15_resp_valid_i,
    input  logic                                 inval_valid_i,
    input  logic [AddrWidth-1:0]                 inval_addr_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic                                 overflow_o,
    output logic [7:0]                           drop_cnt_o
);

    localparam int unsigned LineW = AddrWidth - LineOffW;
    localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);

    logic [LineW-1:0] w_req_line;
    logic [LineW-1:0] w_head_line;
    logic [LineW-1:0] w_tail_line;
    logic             w_head_vld;
    logic             w_tail_vld;
    logic             w_empty;
    logic             w_full;
    logic             w_issue;
    logic             w_skip;
    logic             w_pop;
    logic             w_dup;
    logic             w_new;
    logic             w_push;
    logic             w_drop;
    logic             w_resp;

    logic [OutW-1:0]  r_outstanding;
    logic [LineW-1:0] r_inflight_line;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    assign w_req_line = core_miss_paddr_i[AddrWidth-1:LineOffW];

    icache_miss_fifo #(
        .Depth (Depth),
        .LineW (LineW)
    ) u_fifo (
        .clk_i        (clk_i),
        .reset_l      (reset_l),
        .i_push       (w_push),
        .i_push_line  (w_req_line),
        .i_pop        (w_pop),
        .i_inval      (inval_valid_i),
        .i_inval_line (inval_addr_i[AddrWidth-1:LineOffW]),
        .o_head_line  (w_head_line),
        .o_head_vld   (w_head_vld),
        .o_tail_line  (w_tail_line),
        .o_tail_vld   (w_tail_vld),
        .o_empty      (w_empty),
        .o_full       (w_full)
    );

    // Invalidated entries reaching the head retire silently, independent of credit.
    assign l15_miss_valid_o = !w_empty && w_head_vld && (r_outstanding < OutW'(MaxOutstanding));
    assign l15_miss_paddr_o = {w_head_line, {LineOffW{1'b0}}};
    assign w_issue          = l15_miss_valid_o && l15_miss_ready_i;
    assign w_skip           = !w_empty && !w_head_vld;
    assign w_pop            = w_issue || w_skip;

    assign w_dup  = (!w_empty && w_tail_vld && (w_tail_line == w_req_line)) ||
                    ((r_outstanding != '0) && (r_inflight_line == w_req_line));
    assign w_new  = core_miss_valid_i && !w_dup;
    assign w_push = w_new && (!w_full || w_pop);
    assign w_drop = w_new && w_full && !w_pop;
    assign w_resp = l15_resp_valid_i && (r_outstanding != '0);

    // Credit counter, in-flight line for dedup, and drop statistics.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            r_outstanding   <= '0;
            r_inflight_line <= '0;
            r_overflow      <= 1'b0;
            r_drop_cnt      <= '0;
        end else begin
            if (w_issue && !w_resp) begin
                r_outstanding <= r_outstanding + OutW'(1);
            end else if (!w_issue && w_resp) begin
                r_outstanding <= r_outstanding - OutW'(1);
            end
            if (w_issue) begin
                r_inflight_line <= w_head_line;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    assign outstanding_o = r_outstanding;
    assign overflow_o    = r_overflow;
    assign drop_cnt_o    = r_drop_cnt;

endmodule

// File: doc/icache_miss_req_queue.md
ICACHE_MISS_REQ_QUEUE -- requirements
Module: icache_miss_req_queue

Interface
REQ-001 Parameter Depth, 4, queue entries; power of two, 2..16.
REQ-002 Parameter AddrWidth, 40, physical address width.
REQ-003 Parameter LineOffW, 6, line offset bits (64B, 512-bit line).
REQ-004 Parameter MaxOutstanding, 1, misses issued downstream without a response; 1..4.
REQ-005 clk_i  in  1  clock.
REQ-006 reset_l  in  1  asynchronous, active-low reset.
REQ-007 core_miss_valid_i  in  1  I$ miss request; the core cannot be stalled.
REQ-008 core_miss_paddr_i  in  AddrWidth  miss physical address.
REQ-009 l15_miss_valid_o  out  1  request to L1.5 adapter.
REQ-010 l15_miss_ready_i  in  1  adapter accepts request.
REQ-011 l15_miss_paddr_o  out  AddrWidth  line-aligned address, low LineOffW bits zero.
REQ-012 l15_resp_valid_i  in  1  adapter refill response, one pulse per issued miss.
REQ-013 inval_valid_i  in  1  I$ invalidation from adapter.
REQ-014 inval_addr_i  in  AddrWidth  invalidated line address.
REQ-015 outstanding_o  out  $clog2(MaxOutstanding+1)  issued, unanswered misses.
REQ-016 overflow_o  out  1  sticky: a request was dropped.
REQ-017 drop_cnt_o  out  8  saturating count of dropped requests.

Function
REQ-018 Accepted addresses SHALL be stored line-aligned in a circular FIFO with wr/rd pointers and a count of width $clog2(Depth)+1.
REQ-019 Dedup: a request whose line equals the youngest queued line, or the head in flight, SHALL be discarded silently without counting as a drop.
REQ-020 Full and not deduped: request SHALL be dropped; overflow_o set; drop_cnt_o incremented, saturating at 255.
REQ-021 Full and head popped in the same cycle: request SHALL be accepted, not dropped.
REQ-022 l15_miss_valid_o = queue not empty AND outstanding_o < MaxOutstanding; paddr = head entry; combinational from registers only.
REQ-023 Once valid is asserted, paddr SHALL hold stable until the handshake (valid&ready); an invalidation SHALL NOT retract a presented request.
REQ-024 Pop and outstanding increment SHALL occur on the valid&ready edge; outstanding decrements on l15_resp_valid_i; simultaneous issue and response SHALL leave it unchanged.
REQ-025 l15_resp_valid_i with outstanding_o==0 SHALL be ignored; the counter never underflows.
REQ-026 Empty queue with a new request: earliest l15_miss_valid_o is the next cycle; no combinational bypass.
REQ-027 inval_valid_i SHALL clear the valid bit of every non-head queued entry matching the line; invalid entries are popped without issue, one per cycle.
REQ-028 Invalidation and enqueue of the same line in one cycle: enqueue wins; the entry stays valid.

Reset
REQ-029 reset_l low SHALL asynchronously clear pointers, count, entry valids, outstanding counter, overflow_o and drop_cnt_o.
REQ-030 Outputs SHALL read 0 during reset: l15_miss_valid_o=0, outstanding_o=0, overflow_o=0, drop_cnt_o=0.
REQ-031 Reset mid-transaction SHALL discard all queued and outstanding state; late responses afterwards are ignored per REQ-025.

Structure
REQ-032 The line-address typedef and LineOffW default SHALL live in sargantana_hpdc_pkg; Depth and MaxOutstanding remain module parameters.
REQ-033 One sub-module, icache_miss_fifo (storage, pointers, per-entry valid, inval match), SHALL be instantiated; dedup, issue and outstanding logic stay in the top.
REQ-034 The block SHALL sit between top_tile io_mem_acquire and the adapter icache miss port, replacing the unused ready tie-off.

Verification
REQ-035 Single miss 0x80001234, ready=1 -> next cycle valid, paddr 0x80001200; outstanding 1; response -> 0.
REQ-036 Three requests to 0x80001200/0x80001210/0x80001230, ready=0 -> one entry queued; drop_cnt 0.
REQ-037 Depth=4, ready=0, six distinct lines -> four queued, overflow_o=1, drop_cnt_o=2; after release, issue order matches arrival.
REQ-038 MaxOutstanding=1, two queued, no response -> second not presented; response pulse -> second valid next cycle.
REQ-039 Queued lines A,B,C, head A presented, inval B -> A then C issued; B never appears on l15_miss_paddr_o.
REQ-040 reset_l low while outstanding=1 with two queued -> all outputs 0 asynchronously; a later response leaves outstanding_o at 0.
